// File: rtl/mwrite_if.sv
// MMU data-write port between the memory-write stage (master) and the MMU (slave).
// Latency: none, wires only.
// Backpressure: DATA_WREN is held until the MMU returns a one-cycle DATA_WDONE.
interface mwrite_if #(
    parameter int XLEN = 32
);
    logic            DATA_WREN;
    logic [XLEN-1:0] DATA_WADDR;
    logic [XLEN-1:0] DATA_WDATA;
    logic            DATA_WDONE;

    modport master (
        output DATA_WREN,
        output DATA_WADDR,
        output DATA_WDATA,
        input  DATA_WDONE
    );

    modport slave (
        input  DATA_WREN,
        input  DATA_WADDR,
        input  DATA_WDATA,
        output DATA_WDONE
    );
endinterface

// File: rtl/mwrite.sv
// Memory-write stage: one slot, drives the MMU store port, commits rd/CSR/jump once (MWRITE_TIMEOUT_EN adds a store watchdog).
// Latency: 1 cycle for non-stores; stores commit in the DATA_WDONE cycle (>= 1).
// Backpressure: MEMW_BUSY is high while a store is unacknowledged; capture only when MEM_WAIT=0.
module mwrite #(
    parameter int XLEN = 32
`ifdef MWRITE_TIMEOUT_EN
   ,parameter int TIMEOUT_CYCLES = 1024
`endif
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             FLUSH,
    input  logic             MEM_WAIT,
    output logic             MEMW_BUSY,
    input  logic [4:0]       MEMR_REG_W_RD,
    input  logic [XLEN-1:0]  MEMR_REG_W_DATA,
    input  logic             MEMR_CSR_W_EN,
    input  logic [11:0]      MEMR_CSR_W_ADDR,
    input  logic [XLEN-1:0]  MEMR_CSR_W_DATA,
    input  logic             MEMR_MEM_W_EN,
    input  logic [XLEN-1:0]  MEMR_MEM_W_ADDR,
    input  logic [XLEN-1:0]  MEMR_MEM_W_DATA,
    input  logic             MEMR_JMP_DO,
    input  logic [XLEN-1:0]  MEMR_JMP_PC,
    mwrite_if.master         dmem,
    output logic [4:0]       MEMW_REG_W_RD,
    output logic [XLEN-1:0]  MEMW_REG_W_DATA,
    output logic             MEMW_CSR_W_EN,
    output logic [11:0]      MEMW_CSR_W_ADDR,
    output logic [XLEN-1:0]  MEMW_CSR_W_DATA,
    output logic             MEMW_JMP_DO,
    output logic [XLEN-1:0]  MEMW_JMP_PC,
    output logic             MEMW_ERR
);

    typedef enum logic {IDLE, WRITE} state_t;

    // Store address keeps only the word part; byte offset is always 0 on the port.
    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] rd_dat;
        logic            csr_en;
        logic [11:0]     csr_addr;
        logic [XLEN-1:0] csr_dat;
        logic [XLEN-3:0] st_addr;
        logic [XLEN-1:0] st_dat;
        logic            jmp_do;
        logic [XLEN-1:0] jmp_pc;
    } slot_t;

    state_t state;
    slot_t  slot;
    logic   pend;
    logic   capture;
    logic   timeout;
    logic   done;
    logic   commit;
    logic   new_store;

`ifdef MWRITE_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] tmo_cnt;

    assign timeout = (state == WRITE) && !dmem.DATA_WDONE &&
                     (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    assign capture   = !MEM_WAIT;
    assign new_store = !FLUSH && MEMR_MEM_W_EN;
    // A watchdog expiry retires the store exactly like an acknowledge.
    assign done      = (state == WRITE) && (dmem.DATA_WDONE || timeout);
    assign commit    = pend && ((state == IDLE) || done);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            slot  <= '0;
            pend  <= 1'b0;
        end else begin
            if (capture) begin
                pend <= 1'b1;
                if (FLUSH) begin
                    slot  <= '0;
                    state <= IDLE;
                end else begin
                    slot.rd       <= MEMR_REG_W_RD;
                    slot.rd_dat   <= MEMR_REG_W_DATA;
                    slot.csr_en   <= MEMR_CSR_W_EN;
                    slot.csr_addr <= MEMR_CSR_W_ADDR;
                    slot.csr_dat  <= MEMR_CSR_W_DATA;
                    slot.st_addr  <= MEMR_MEM_W_ADDR[XLEN-1:2];
                    slot.st_dat   <= MEMR_MEM_W_DATA;
                    slot.jmp_do   <= MEMR_JMP_DO;
                    slot.jmp_pc   <= MEMR_JMP_PC;
                    state         <= MEMR_MEM_W_EN ? WRITE : IDLE;
                end
            end else begin
                if (commit)
                    pend <= 1'b0;
                if (done)
                    state <= IDLE;
            end
        end
    end

`ifdef MWRITE_TIMEOUT_EN
    always_ff @(posedge CLK) begin
        if (RST)
            tmo_cnt <= '0;
        else if (capture && new_store)
            tmo_cnt <= '0;
        else if (state == WRITE)
            tmo_cnt <= tmo_cnt + CW'(1);
    end
`endif

    assign MEMW_BUSY       = (state == WRITE) && !done;
    assign MEMW_ERR        = timeout;

    assign dmem.DATA_WREN  = (state == WRITE);
    assign dmem.DATA_WADDR = {slot.st_addr, 2'b00};
    assign dmem.DATA_WDATA = slot.st_dat;

    assign MEMW_REG_W_RD   = commit ? slot.rd : 5'd0;
    assign MEMW_REG_W_DATA = slot.rd_dat;
    assign MEMW_CSR_W_EN   = commit && slot.csr_en;
    assign MEMW_CSR_W_ADDR = slot.csr_addr;
    assign MEMW_CSR_W_DATA = slot.csr_dat;
    assign MEMW_JMP_DO     = commit && slot.jmp_do;
    assign MEMW_JMP_PC     = slot.jmp_pc;

endmodule

// File: tb/tb_mwrite.sv
// Bench for mwrite: commit scoreboard plus per-scenario cycle checks on the store port.
// Latency: n/a. Backpressure: MEM_WAIT is modelled as MEMW_BUSY OR a bench stall.
// Inputs change just after posedge, outputs are sampled on negedge.
module tb_mwrite;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, flush, stall, mem_wait, memw_busy;
    logic [4:0]  r_rd;
    logic [31:0] r_rdat, r_cdat, r_saddr, r_sdat, r_pc;
    logic        r_csr_en, r_st, r_jmp;
    logic [11:0] r_caddr;
    logic [4:0]  w_rd;
    logic [31:0] w_rdat, w_cdat, w_pc;
    logic        w_csr_en, w_jmp, w_err;
    logic [11:0] w_caddr;

    mwrite_if #(.XLEN(32)) dmem ();

    assign mem_wait = memw_busy | stall;

    mwrite #(
        .XLEN(32)
`ifdef MWRITE_TIMEOUT_EN
       ,.TIMEOUT_CYCLES(8)
`endif
    ) u_dut (
        .CLK(clk), .RST(rst), .FLUSH(flush), .MEM_WAIT(mem_wait), .MEMW_BUSY(memw_busy),
        .MEMR_REG_W_RD(r_rd), .MEMR_REG_W_DATA(r_rdat),
        .MEMR_CSR_W_EN(r_csr_en), .MEMR_CSR_W_ADDR(r_caddr), .MEMR_CSR_W_DATA(r_cdat),
        .MEMR_MEM_W_EN(r_st), .MEMR_MEM_W_ADDR(r_saddr), .MEMR_MEM_W_DATA(r_sdat),
        .MEMR_JMP_DO(r_jmp), .MEMR_JMP_PC(r_pc),
        .dmem(dmem),
        .MEMW_REG_W_RD(w_rd), .MEMW_REG_W_DATA(w_rdat),
        .MEMW_CSR_W_EN(w_csr_en), .MEMW_CSR_W_ADDR(w_caddr), .MEMW_CSR_W_DATA(w_cdat),
        .MEMW_JMP_DO(w_jmp), .MEMW_JMP_PC(w_pc), .MEMW_ERR(w_err)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] rdat;
        logic        csr_en;
        logic [11:0] caddr;
        logic [31:0] cdat;
        logic        jmp;
        logic [31:0] pc;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic drive(input logic [4:0] rd, input logic [31:0] rdat,
                         input logic csr_en, input logic [11:0] caddr, input logic [31:0] cdat,
                         input logic st, input logic [31:0] saddr, input logic [31:0] sdat,
                         input logic jmp, input logic [31:0] pc);
        r_rd = rd; r_rdat = rdat; r_csr_en = csr_en; r_caddr = caddr; r_cdat = cdat;
        r_st = st; r_saddr = saddr; r_sdat = sdat; r_jmp = jmp; r_pc = pc;
    endtask

    task automatic idle();
        drive(5'd0, 32'd0, 1'b0, 12'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
    endtask

    // Expected commit of the instruction currently on the MEMR inputs.
    task automatic push_exp();
        exp_t e;
        e.rd = r_rd; e.rdat = r_rdat; e.csr_en = r_csr_en; e.caddr = r_caddr;
        e.cdat = r_cdat; e.jmp = r_jmp; e.pc = r_pc;
        sb.push_back(e);
    endtask

    // Sample at negedge; any visible commit must match the scoreboard head.
    task automatic sample();
        exp_t e;
        logic [114:0] got, want;
        @(negedge clk);
        if (w_rd != 5'd0 || w_csr_en || w_jmp) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_commit got rd=%0d csr=%0b jmp=%0b, required none",
                         w_rd, w_csr_en, w_jmp);
            end else begin
                e    = sb.pop_front();
                got  = {w_rd, w_rdat, w_csr_en, w_caddr, w_cdat, w_jmp, w_pc};
                want = {e.rd, e.rdat, e.csr_en, e.caddr, e.cdat, e.jmp, e.pc};
                if (got !== want) begin
                    errors++;
                    $display("FAIL sb_commit got=%h required=%h", got, want);
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; flush = 1'b0; dmem.DATA_WDONE = 1'b0; idle();
        repeat (2) step();
        sample();
        checks++; if ({w_rd, w_csr_en, w_jmp, w_err} !== 8'd0) begin errors++;
            $display("FAIL reset_ctrl got=%h required=0", {w_rd, w_csr_en, w_jmp, w_err}); end
        checks++; if ({w_rdat, w_cdat, w_pc, w_caddr} !== 108'd0) begin errors++;
            $display("FAIL reset_data got=%h required=0", {w_rdat, w_cdat, w_pc, w_caddr}); end
        checks++; if ({dmem.DATA_WREN, memw_busy, dmem.DATA_WADDR, dmem.DATA_WDATA} !== 66'd0) begin
            errors++; $display("FAIL reset_port got wren=%b busy=%b addr=%h required 0",
                               dmem.DATA_WREN, memw_busy, dmem.DATA_WADDR); end
        step();
        rst = 1'b0;
        sample();
        step();
    endtask

    task automatic test_reg_csr();
        drive(5'd5, 32'h1234, 1'b0, 12'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
        push_exp(); sample(); step();
        idle(); sample();
        checks++; if (w_rd !== 5'd5 || w_rdat !== 32'h1234) begin errors++;
            $display("FAIL reg_commit got rd=%0d dat=%h required 5/1234", w_rd, w_rdat); end
        step();
        drive(5'd0, 32'd0, 1'b1, 12'h300, 32'hDEADBEEF, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
        push_exp(); sample();
        checks++; if (w_rd !== 5'd0) begin errors++;
            $display("FAIL reg_once got rd=%0d required 0", w_rd); end
        step();
        idle(); sample();
        checks++; if (w_csr_en !== 1'b1 || w_caddr !== 12'h300) begin errors++;
            $display("FAIL csr_commit got en=%b addr=%h required 1/300", w_csr_en, w_caddr); end
        step();
        sample();
        checks++; if (w_csr_en !== 1'b0) begin errors++;
            $display("FAIL csr_once got en=%b required 0", w_csr_en); end
        step();
    endtask

    task automatic test_idle_wdone();
        dmem.DATA_WDONE = 1'b1;
        drive(5'd9, 32'h99, 1'b0, 12'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
        push_exp(); sample();
        checks++; if (dmem.DATA_WREN !== 1'b0 || memw_busy !== 1'b0) begin errors++;
            $display("FAIL idle_wdone got wren=%b busy=%b required 0/0", dmem.DATA_WREN, memw_busy); end
        step();
        idle(); sample(); step();
        dmem.DATA_WDONE = 1'b0;
        sample(); step();
    endtask

    task automatic test_store();
        drive(5'd0, 32'd0, 1'b0, 12'd0, 32'd0, 1'b1, 32'h1002, 32'hAABBCCDD, 1'b0, 32'd0);
        sample(); step();
        idle();
        for (int c = 1; c <= 3; c++) begin
            flush = (c < 3);
            dmem.DATA_WDONE = (c == 3);
            sample();
            checks++;
            if (dmem.DATA_WREN !== 1'b1 || dmem.DATA_WADDR !== 32'h1000 ||
                dmem.DATA_WDATA !== 32'hAABBCCDD || memw_busy !== (c < 3)) begin
                errors++;
                $display("FAIL store_c%0d got wren=%b addr=%h dat=%h busy=%b required 1/1000/aabbccdd/%0b",
                         c, dmem.DATA_WREN, dmem.DATA_WADDR, dmem.DATA_WDATA, memw_busy, (c < 3));
            end
            step();
        end
        flush = 1'b0; dmem.DATA_WDONE = 1'b0;
        sample();
        checks++; if (dmem.DATA_WREN !== 1'b0 || memw_busy !== 1'b0) begin errors++;
            $display("FAIL store_end got wren=%b busy=%b required 0/0", dmem.DATA_WREN, memw_busy); end
        step();
    endtask

    task automatic test_back_to_back();
        drive(5'd3, 32'h33, 1'b0, 12'd0, 32'd0, 1'b1, 32'h100, 32'h11111111, 1'b0, 32'd0);
        push_exp(); sample(); step();
        drive(5'd4, 32'h44, 1'b0, 12'd0, 32'd0, 1'b1, 32'h104, 32'h22222222, 1'b0, 32'd0);
        sample();
        checks++; if (dmem.DATA_WREN !== 1'b1 || dmem.DATA_WADDR !== 32'h100 || memw_busy !== 1'b1) begin
            errors++; $display("FAIL b2b_first got wren=%b addr=%h busy=%b required 1/100/1",
                               dmem.DATA_WREN, dmem.DATA_WADDR, memw_busy); end
        step();
        dmem.DATA_WDONE = 1'b1;
        push_exp(); sample();
        checks++; if (w_rd !== 5'd3 || memw_busy !== 1'b0) begin errors++;
            $display("FAIL b2b_commit1 got rd=%0d busy=%b required 3/0", w_rd, memw_busy); end
        step();
        idle(); dmem.DATA_WDONE = 1'b0; sample();
        checks++; if (dmem.DATA_WREN !== 1'b1 || dmem.DATA_WADDR !== 32'h104 ||
                      dmem.DATA_WDATA !== 32'h22222222 || w_rd !== 5'd0) begin
            errors++; $display("FAIL b2b_second got wren=%b addr=%h dat=%h rd=%0d required 1/104/22222222/0",
                               dmem.DATA_WREN, dmem.DATA_WADDR, dmem.DATA_WDATA, w_rd); end
        step();
        dmem.DATA_WDONE = 1'b1; sample();
        checks++; if (w_rd !== 5'd4) begin errors++;
            $display("FAIL b2b_commit2 got rd=%0d required 4", w_rd); end
        step();
        dmem.DATA_WDONE = 1'b0; sample();
        checks++; if (dmem.DATA_WREN !== 1'b0) begin errors++;
            $display("FAIL b2b_end got wren=%b required 0", dmem.DATA_WREN); end
        step();
    endtask

    task automatic test_stall();
        drive(5'd6, 32'h66, 1'b0, 12'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
        push_exp(); sample(); step();
        idle(); stall = 1'b1; flush = 1'b1; sample(); step();
        sample();
        checks++; if (w_rd !== 5'd0) begin errors++;
            $display("FAIL stall_no_repeat got rd=%0d required 0", w_rd); end
        step();
        stall = 1'b0; flush = 1'b0;
        drive(5'd8, 32'h88, 1'b0, 12'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
        push_exp(); sample();
        checks++; if (w_rdat !== 32'h66) begin errors++;
            $display("FAIL stall_hold got dat=%h required 66", w_rdat); end
        step();
        idle(); sample(); step();
    endtask

    task automatic test_jump_flush();
        drive(5'd0, 32'd0, 1'b0, 12'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b1, 32'h8000);
        push_exp(); sample(); step();
        drive(5'd10, 32'h55, 1'b1, 12'h123, 32'h77, 1'b1, 32'h500, 32'h9, 1'b1, 32'h4444);
        flush = 1'b1; sample();
        checks++; if (w_jmp !== 1'b1 || w_pc !== 32'h8000) begin errors++;
            $display("FAIL jump_commit got jmp=%b pc=%h required 1/8000", w_jmp, w_pc); end
        step();
        flush = 1'b0; idle(); sample();
        checks++; if ({w_rd, w_csr_en, w_jmp, dmem.DATA_WREN} !== 8'd0 ||
                      {w_rdat, w_pc, w_caddr} !== 76'd0) begin
            errors++; $display("FAIL flush_bubble got rd=%0d csr=%b jmp=%b wren=%b dat=%h pc=%h required all 0",
                               w_rd, w_csr_en, w_jmp, dmem.DATA_WREN, w_rdat, w_pc); end
        step();
    endtask

    task automatic test_reset_abort();
        drive(5'd0, 32'd0, 1'b0, 12'd0, 32'd0, 1'b1, 32'h2000, 32'h5A5A5A5A, 1'b0, 32'd0);
        sample(); step();
        idle(); sample();
        checks++; if (dmem.DATA_WREN !== 1'b1) begin errors++;
            $display("FAIL abort_pre got wren=%b required 1", dmem.DATA_WREN); end
        step();
        rst = 1'b1; sample(); step();
        rst = 1'b0; sample();
        checks++; if (dmem.DATA_WREN !== 1'b0 || memw_busy !== 1'b0) begin errors++;
            $display("FAIL abort_post got wren=%b busy=%b required 0/0", dmem.DATA_WREN, memw_busy); end
        step();
    endtask

`ifdef MWRITE_TIMEOUT_EN
    task automatic test_timeout();
        drive(5'd11, 32'hBB, 1'b0, 12'd0, 32'd0, 1'b1, 32'h3000, 32'h1, 1'b0, 32'd0);
        push_exp(); sample(); step();
        idle();
        for (int c = 1; c <= 8; c++) begin
            sample();
            checks++;
            if (w_err !== (c == 8) || memw_busy !== (c < 8) || w_rd !== ((c == 8) ? 5'd11 : 5'd0)) begin
                errors++;
                $display("FAIL timeout_c%0d got err=%b busy=%b rd=%0d", c, w_err, memw_busy, w_rd);
            end
            step();
        end
        sample();
        checks++; if (w_err !== 1'b0 || dmem.DATA_WREN !== 1'b0) begin errors++;
            $display("FAIL timeout_end got err=%b wren=%b required 0/0", w_err, dmem.DATA_WREN); end
        step();
    endtask
`endif

    initial begin
        test_reset();
        test_reg_csr();
        test_idle_wdone();
        test_store();
        test_back_to_back();
        test_stall();
        test_jump_flush();
        test_reset_abort();
`ifdef MWRITE_TIMEOUT_EN
        test_timeout();
`endif
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain got %0d pending commits required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mwrite.md
Name: mwrite

Overview:
- Memory-write pipeline stage, directly downstream of the memory-read stage.
- Captures that stage's MEMR_* bundle (register/CSR writeback, merged store word, jump) into one pipeline slot.
- Drives the MMU data-write port and holds the pipeline until the MMU acknowledges the store.
- Presents each instruction's register/CSR/jump commit to writeback and fetch exactly once.

Parameters:
- XLEN, 32, data/address width
- TIMEOUT_CYCLES, 1024, store-acknowledge watchdog limit; used only with MWRITE_TIMEOUT_EN

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous active-high reset
- FLUSH  in  1  load a bubble instead of upstream data at the next capture
- MEM_WAIT  in  1  global stall, includes this block's MEMW_BUSY; blocks capture
- MEMW_BUSY  out  1  store outstanding; top level ORs it into MEM_WAIT
- MEMR_REG_W_RD  in  5  upstream rd (0 = no write)
- MEMR_REG_W_DATA  in  XLEN  upstream rd data
- MEMR_CSR_W_EN  in  1  CSR write enable
- MEMR_CSR_W_ADDR  in  12  CSR address
- MEMR_CSR_W_DATA  in  XLEN  CSR data
- MEMR_MEM_W_EN  in  1  store request
- MEMR_MEM_W_ADDR  in  XLEN  store address
- MEMR_MEM_W_DATA  in  XLEN  merged full store word
- MEMR_JMP_DO  in  1  jump request
- MEMR_JMP_PC  in  XLEN  jump target
- DATA_WREN  out  1  MMU write request
- DATA_WADDR  out  XLEN  word address, bits[1:0] forced to 0
- DATA_WDATA  out  XLEN  write data
- DATA_WDONE  in  1  MMU one-cycle write acknowledge
- MEMW_REG_W_RD  out  5  rd at commit, else 0
- MEMW_REG_W_DATA  out  XLEN  registered rd data
- MEMW_CSR_W_EN  out  1  CSR enable at commit only
- MEMW_CSR_W_ADDR  out  12  registered CSR address
- MEMW_CSR_W_DATA  out  XLEN  registered CSR data
- MEMW_JMP_DO  out  1  jump at commit only
- MEMW_JMP_PC  out  XLEN  registered jump target
- MEMW_ERR  out  1  store timeout pulse; tied 0 without MWRITE_TIMEOUT_EN

Behaviour:
- Reset:
  - All slot registers are 0; pend=0; state=IDLE.
  - All outputs are 0.
- Capture:
  - A capture occurs when MEM_WAIT=0.
  - If FLUSH=1, a bubble is captured: all fields 0.
  - Otherwise the MEMR_* inputs are captured.
  - Every capture sets pend=1.
  - With MEM_WAIT=1 the slot holds and FLUSH has no effect.
- FSM states:
  - IDLE to WRITE: on a capture of MEM_W_EN=1.
  - WRITE: DATA_WREN=1, DATA_WADDR/DATA_WDATA stable from the slot; MEMW_BUSY = !DATA_WDONE.
  - WRITE to IDLE: on DATA_WDONE; if the same cycle captures a new store, the FSM stays in WRITE for the new store.
- Commit:
  - commit = pend && (state==IDLE || DATA_WDONE).
  - Non-store commits the cycle after capture, so latency is 1.
  - Store commits in the DATA_WDONE cycle, so latency is at least 1.
  - MEMW_REG_W_RD, MEMW_CSR_W_EN and MEMW_JMP_DO are gated by commit; data/address/PC outputs always show slot values.
  - On commit pend clears, unless a capture happens in the same cycle (capture wins).
  - A stall from another source after commit never repeats the commit, because pend=0.
- Boundary conditions:
  - DATA_WDONE while in IDLE is ignored.
  - Back-to-back stores: WDONE and the capture of the next store fall in the same cycle; DATA_WREN stays 1 with the new address on the next cycle.
  - Bubble (all fields 0): commits with no effect.
  - RST during WRITE drops DATA_WREN on the next edge; the MMU side must tolerate the abort.
  - FLUSH never aborts an in-flight store.

Optional Feature:
- MWRITE_TIMEOUT_EN defined:
  - A counter clears on entry to WRITE and increments each WRITE cycle.
  - When it reaches TIMEOUT_CYCLES-1 without DATA_WDONE: MEMW_ERR pulses 1 cycle, the FSM returns to IDLE, the instruction commits normally (store dropped), and MEMW_BUSY falls.
- Not defined: no counter; MEMW_ERR=0; a store waits for DATA_WDONE indefinitely.

Test Plan:
- Reset, then idle inputs -> all outputs 0; DATA_WREN=0; MEMW_BUSY=0.
- MEMR_REG_W_RD=5, DATA=0x1234, no store -> next cycle MEMW_REG_W_RD=5, DATA=0x1234 for exactly 1 cycle, then rd=0.
- Store addr 0x1002, data 0xAABBCCDD, rd=0; DATA_WDONE after 3 cycles -> DATA_WREN=1, DATA_WADDR=0x1000 for 3 cycles; MEMW_BUSY=1 for the first 2; single commit at the WDONE cycle.
- Two back-to-back stores (0x100, 0x104) with WDONE 2 cycles after each request -> DATA_WREN held continuously; address switches to 0x104 the cycle after the first WDONE; two commits.
- Jump to 0x8000 with FLUSH asserted in the capture cycle of the following instruction -> MEMW_JMP_DO=1 for one cycle; next slot is a bubble (rd=0, no CSR, no store).
- MWRITE_TIMEOUT_EN, TIMEOUT_CYCLES=8, store never acknowledged -> MEMW_ERR pulses at the 8th WRITE cycle, BUSY falls, commit occurs once.
